// File: rtl/onchip_mem_port_arbiter_pkg.sv
// Shared widths and the in-flight read tag record for the on-chip RAM port arbiter.
package onchip_arb_pkg;
  localparam int MEM_ADDR_W = 17;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = 4;
  localparam int READ_LAT   = 2;
  localparam int ID_W       = 2;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/onchip_mem_port_arbiter_if.sv
// Requester fabric and RAM port bundle; the arbiter uses the slave side.
interface onchip_mem_port_arbiter_if #(
  parameter int NUM_REQ = 3
);
  import onchip_arb_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*MEM_ADDR_W-1:0] req_addr;
  logic [NUM_REQ*MEM_BE_W-1:0]   req_byteenable;
  logic [NUM_REQ*MEM_DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [MEM_DATA_W-1:0]         rsp_rdata;
  logic [MEM_ADDR_W-1:0]         mem_address;
  logic                          mem_chipselect;
  logic                          mem_write;
  logic [MEM_BE_W-1:0]           mem_byteenable;
  logic [MEM_DATA_W-1:0]         mem_writedata;
  logic                          mem_clken;
  logic [MEM_DATA_W-1:0]         mem_readdata;

  modport master (
    output req_valid, req_write, req_lock, req_addr, req_byteenable, req_wdata, mem_readdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_address, mem_chipselect, mem_write,
           mem_byteenable, mem_writedata, mem_clken
  );

  modport slave (
    input  req_valid, req_write, req_lock, req_addr, req_byteenable, req_wdata, mem_readdata,
    output req_ready, rsp_valid, rsp_rdata, mem_address, mem_chipselect, mem_write,
           mem_byteenable, mem_writedata, mem_clken
  );
endinterface

// File: rtl/onchip_mem_port_arbiter_rr_pick.sv
// Circular priority select: one-hot grant to the first valid bit after i_last.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_valid,
  input  logic [PTR_W-1:0] i_last,
  output logic [N-1:0]     o_grant
);
  logic w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    // Positions above the pointer first, then wrap to the low end.
    for (int i = 0; i < N; i++) begin
      if (!w_found && i_valid[i] && (i > int'(i_last))) begin
        o_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_found && i_valid[i] && (i <= int'(i_last))) begin
        o_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/onchip_mem_port_arbiter.sv
// Round-robin arbiter with bounded lock sharing one on-chip RAM port; registers the
// RAM command and routes each read word back to its requester.
module onchip_mem_port_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 8
) (
  input logic                      i_clk,
  input logic                      i_reset,
  onchip_mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = 8;

  logic [NUM_REQ-1:0]    w_rr_grant;
  logic [NUM_REQ-1:0]    w_hold_vec;
  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_accept;
  logic [ID_W-1:0]       w_grant_id;
  logic                  w_sel_write;
  logic                  w_sel_lock;
  logic [MEM_ADDR_W-1:0] w_sel_addr;
  logic [MEM_BE_W-1:0]   w_sel_be;
  logic [MEM_DATA_W-1:0] w_sel_wdata;

  logic [ID_W-1:0]       r_last_grant;
  logic                  r_last_lock;
  logic [CNT_W-1:0]      r_burst_cnt;
  tag_t                  r_tag [READ_LAT];
  logic [MEM_ADDR_W-1:0] r_mem_address;
  logic                  r_mem_chipselect;
  logic                  r_mem_write;
  logic [MEM_BE_W-1:0]   r_mem_byteenable;
  logic [MEM_DATA_W-1:0] r_mem_writedata;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [MEM_DATA_W-1:0] r_rsp_rdata;

  rr_pick #(.N(NUM_REQ), .PTR_W(ID_W)) u_rr_pick (
    .i_valid (bus.req_valid),
    .i_last  (r_last_grant),
    .o_grant (w_rr_grant)
  );

  always_comb begin
    w_hold_vec  = '0;
    w_grant_id  = '0;
    w_sel_write = 1'b0;
    w_sel_lock  = 1'b0;
    w_sel_addr  = '0;
    w_sel_be    = '0;
    w_sel_wdata = '0;
    // A locked requester keeps the port until its burst count reaches the limit.
    for (int i = 0; i < NUM_REQ; i++) begin
      w_hold_vec[i] = r_last_lock && bus.req_valid[i] && (r_last_grant == ID_W'(i)) &&
                      (r_burst_cnt < CNT_W'(MAX_BURST));
    end
    w_grant = (|w_hold_vec) ? w_hold_vec : w_rr_grant;
    if (i_reset) w_grant = '0;
    w_accept = |w_grant;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_grant_id  = ID_W'(i);
        w_sel_write = bus.req_write[i];
        w_sel_lock  = bus.req_lock[i];
        w_sel_addr  = bus.req_addr[i*MEM_ADDR_W +: MEM_ADDR_W];
        w_sel_be    = bus.req_byteenable[i*MEM_BE_W +: MEM_BE_W];
        w_sel_wdata = bus.req_wdata[i*MEM_DATA_W +: MEM_DATA_W];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_grant     <= ID_W'(NUM_REQ - 1);
      r_last_lock      <= 1'b0;
      r_burst_cnt      <= '0;
      r_mem_address    <= '0;
      r_mem_chipselect <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_byteenable <= '0;
      r_mem_writedata  <= '0;
      r_rsp_valid      <= '0;
      r_rsp_rdata      <= '0;
      for (int s = 0; s < READ_LAT; s++) r_tag[s] <= '0;
    end else begin
      r_mem_chipselect <= w_accept;
      r_mem_write      <= w_accept && w_sel_write;
      if (w_accept) begin
        r_mem_address    <= w_sel_addr;
        r_mem_byteenable <= w_sel_be;
        r_mem_writedata  <= w_sel_wdata;
        r_last_grant     <= w_grant_id;
        r_last_lock      <= w_sel_lock;
        // Restarting at 1 after the limit lets a lone locked requester re-arm its lock.
        r_burst_cnt      <= ((w_grant_id == r_last_grant) && (r_burst_cnt < CNT_W'(MAX_BURST))) ?
                            r_burst_cnt + CNT_W'(1) : CNT_W'(1);
      end else begin
        r_burst_cnt <= '0;
      end
      r_tag[0] <= '{valid: w_accept && !w_sel_write, id: w_grant_id};
      for (int s = 1; s < READ_LAT; s++) r_tag[s] <= r_tag[s-1];
      for (int i = 0; i < NUM_REQ; i++) begin
        r_rsp_valid[i] <= r_tag[READ_LAT-1].valid && (r_tag[READ_LAT-1].id == ID_W'(i));
      end
      if (r_tag[READ_LAT-1].valid) r_rsp_rdata <= bus.mem_readdata;
    end
  end

  assign bus.req_ready      = w_grant;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_rdata      = r_rsp_rdata;
  assign bus.mem_address    = r_mem_address;
  assign bus.mem_chipselect = r_mem_chipselect;
  assign bus.mem_write      = r_mem_write;
  assign bus.mem_byteenable = r_mem_byteenable;
  assign bus.mem_writedata  = r_mem_writedata;
  assign bus.mem_clken      = 1'b1;
endmodule

// File: doc/onchip_mem_port_arbiter.md
# onchip_mem_port_arbiter

Shares one port of the dual-port on-chip program/data RAM (32-bit words, 17-bit word address, byte enables, 1-cycle registered-address read) between up to four Avalon-style requesters, e.g. the audio sample DMA, the voice-feature engine and the game logic. Requests are selected round-robin, with an optional bounded lock for short bursts. The block registers the RAM command, tracks in-flight reads and routes each read word back to its originator. It sits between the requester fabric and the RAM's `address`/`chipselect`/`write`/`writedata`/`byteenable`/`clken` port pins.

## Interface
- NUM_REQ, 3: number of requesters, 2..4.
- MAX_BURST, 8: maximum consecutive grants to a locked requester, 1..255.
- clk  in  1  single clock, shared with the RAM.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request strobe.
- req_ready  out  NUM_REQ  per-requester accept; a transfer happens when valid&ready at the edge.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  holds the grant across consecutive requests.
- req_addr  in  NUM_REQ*17  word address, packed with requester i at [17i+16:17i].
- req_byteenable  in  NUM_REQ*4  byte lanes, packed.
- req_wdata  in  NUM_REQ*32  write data, packed.
- rsp_valid  out  NUM_REQ  read data valid, one cycle per read.
- rsp_rdata  out  32  read data, shared by all requesters; qualified by rsp_valid.
- mem_address  out  17  RAM address, registered.
- mem_chipselect  out  1  RAM chipselect, registered.
- mem_write  out  1  RAM write, registered.
- mem_byteenable  out  4  RAM byte enables, registered.
- mem_writedata  out  32  RAM write data, registered.
- mem_clken  out  1  RAM clock enable; constant 1 out of reset.
- mem_readdata  in  32  RAM q, valid the cycle after the RAM samples the address.

## Operation
- **Arbitration.** Combinational in cycle t. Of the asserted req_valid bits, pick the first one after last_grant in circular order. req_ready is one-hot, or all zero when no requester is valid; it never asserts for a requester whose req_valid is low.
- **Lock.** Suppose the previous accept went to requester g, its req_lock was 1, g is still valid, and burst_cnt < MAX_BURST. Then g wins regardless of rotation.
  - burst_cnt increments on each consecutive accept to the same requester.
  - It clears on an accept by a different requester, or on any cycle with no accept.
  - When burst_cnt reaches MAX_BURST, g loses priority for one arbitration. It still wins if it is the only valid requester.
- **Accept.** On an accept at edge k:
  - The mem_* outputs load the selected command, with mem_chipselect=1 and mem_write=req_write.
  - last_grant is updated.
  - On a cycle with no accept, mem_chipselect=0 and mem_write=0; address, byteenable and writedata hold their previous values.
- **Read tracking.** A 2-stage pipeline of {valid, id} tracks each read. Writes enter the pipeline with valid=0 and produce no response.
- **Response.** A read accepted at edge k yields rsp_valid[id]=1 and rsp_rdata=mem_readdata (registered at edge k+2) in the cycle after edge k+2. rsp_rdata holds its last value otherwise.
- **Read-after-write, same address, back to back.** The read returns the newly written data. This holds because the write is on the same port one cycle earlier, so no bypass logic is needed.
- **Reset.**
  - All outputs go to 0 on the next edge, except mem_clken=1.
  - last_grant resets to NUM_REQ-1, so requester 0 has first priority.
  - burst_cnt resets to 0.
  - In-flight reads are discarded with no rsp_valid. A requester waiting on a read must also reset.

## Timing
- Throughput: one access per cycle sustained, no bubbles between different requesters.
- Read latency: 2 clocks from the accepting edge to rsp_valid high. Writes commit at the RAM on edge k+1.
- Combinational path req_valid → req_ready: one priority rotation over NUM_REQ bits. No path from mem_readdata to req_ready.
- Simultaneous events: a response is delivered to requester i in the same cycle it issues a new request; both occur.

## Structure
- Package `onchip_arb_pkg` holds:
  - MEM_ADDR_W=17, MEM_DATA_W=32, MEM_BE_W=4, READ_LAT=2.
  - The type of the in-flight tag record {valid, id[1:0]}.
- Sub-module `rr_pick`: combinational circular priority select. Inputs are the valid vector and the last_grant pointer; output is a one-hot grant vector. It is reused by other fabric arbiters.
- The top level holds the lock/burst counter, the command register, the tag pipeline and the response register.

## Test plan
- **Round-robin:** req_valid=3'b111 held for 6 cycles, all reads → grant order 0,1,2,0,1,2. rsp_valid follows the same order 2 clocks later, with data matching preloaded RAM words.
- **Write then read:** requester 1 writes 0xDEADBEEF to address 0x00010 with byteenable 4'b0011. Requester 2 then reads 0x00010 on the next cycle → rsp_rdata = {old[31:16], 16'hBEEF}, and rsp_valid[2] pulses 2 clocks after its accept.
- **Burst limit:** MAX_BURST=4; requester 0 has req_lock=1 and valid continuously, requester 1 is valid → grants 0,0,0,0,1,0,0,0,0,1…
- **Lone locked requester:** only requester 2 is valid, with req_lock=1, for 20 cycles → granted all 20 cycles, with no idle cycle at the burst boundary.
- **Reset mid-flight:** assert reset the cycle after accepting reads from requesters 0 and 1 → no rsp_valid afterwards. mem_chipselect=0 and last_grant selects requester 0 first after reset is released.
- **Idle:** req_valid=0 → mem_chipselect=0 and mem_write=0, mem_clken=1, rsp_valid=0.
